// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Round-robin data-memory arbiter for LSU (port 0) and DMA/debug
//           (port 1, fixed-length bursts). Define DMEM_ARB_MISALIGN_CHECK_EN
//           to screen misaligned halfword/word accesses.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int LEN_W  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [2:0]        p0_funct3_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [31:0]       p0_wdata_i,
  output logic              p0_gnt_o,
  output logic              p0_rvalid_o,
  output logic [31:0]       p0_rdata_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [2:0]        p1_funct3_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_wdata_i,
  input  logic [LEN_W-1:0]  p1_len_i,
  output logic              p1_gnt_o,
  output logic              p1_rvalid_o,
  output logic [31:0]       p1_rdata_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  output logic [2:0]        mem_funct3_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o,
  output logic              misalign_err_o
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          f3_q, f3_d;
  logic                we_q, we_d;
  logic                p0_rvalid_q, p1_rvalid_q, err_q;
  logic [31:0]         p0_rdata_q, p1_rdata_q;

  logic                w_in_burst, w_gnt0, w_gnt1, w_gnt, w_sel1;
  logic [2:0]          w_f3;
  logic [ADDR_W-1:0]   w_addr, w_size;
  logic                w_we, w_illegal, w_misalign, w_fwd, w_start;
  logic [31:0]         w_wdata;

  always_comb begin
    w_in_burst = (state_q == S_BURST);
    // Grants are suppressed while reset is held so an aborted burst issues nothing.
    w_gnt0 = !rst && !w_in_burst && p0_req_i && (!p1_req_i || last_q);
    w_gnt1 = !rst && p1_req_i && (w_in_burst || !p0_req_i || !last_q);
    w_gnt  = w_gnt0 || w_gnt1;
    w_sel1 = w_in_burst || w_gnt1;

    w_f3    = w_in_burst ? f3_q   : (w_gnt1 ? p1_funct3_i : p0_funct3_i);
    w_addr  = w_in_burst ? addr_q : (w_gnt1 ? p1_addr_i   : p0_addr_i);
    w_we    = w_in_burst ? we_q   : (w_gnt1 ? p1_we_i     : p0_we_i);
    w_wdata = w_sel1 ? p1_wdata_i : p0_wdata_i;

    case (w_f3[1:0])
      2'b00:   w_size = ADDR_W'(1);
      2'b01:   w_size = ADDR_W'(2);
      default: w_size = ADDR_W'(4);
    endcase

    w_illegal = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    w_misalign = ((w_f3[1:0] == 2'b01) && w_addr[0]) ||
                 ((w_f3 == 3'b010) && (w_addr[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
    w_fwd   = w_gnt && !w_illegal && !w_misalign;
    w_start = w_gnt1 && !w_in_burst && (p1_len_i != '0) && !w_misalign;

    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    we_d    = we_q;
    case (state_q)
      S_IDLE: begin
        if (w_gnt0) last_d = 1'b0;
        if (w_gnt1) last_d = 1'b1;
        if (w_start) begin
          state_d = S_BURST;
          cnt_d   = p1_len_i;
          addr_d  = w_addr + w_size;
          f3_d    = p1_funct3_i;
          we_d    = p1_we_i;
        end
      end
      S_BURST: begin
        last_d = 1'b1;
        if (w_gnt1) begin
          cnt_d  = cnt_q - CNT_ONE;
          addr_d = addr_q + w_size;
          if (w_misalign || (cnt_q == CNT_ONE)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      addr_q      <= '0;
      f3_q        <= 3'b000;
      we_q        <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      f3_q        <= f3_d;
      we_q        <= we_d;
      p0_rvalid_q <= w_gnt0;
      p1_rvalid_q <= w_gnt1;
      err_q       <= w_gnt && w_misalign;
      if (w_gnt0) p0_rdata_q <= (w_fwd && !w_we) ? mem_rdata_i : 32'h0;
      if (w_gnt1) p1_rdata_q <= (w_fwd && !w_we) ? mem_rdata_i : 32'h0;
    end
  end

  assign p0_gnt_o       = w_gnt0;
  assign p1_gnt_o       = w_gnt1;
  assign p0_rvalid_o    = p0_rvalid_q;
  assign p1_rvalid_o    = p1_rvalid_q;
  assign p0_rdata_o     = p0_rdata_q;
  assign p1_rdata_o     = p1_rdata_q;
  assign mem_write_o    = w_fwd && w_we;
  assign mem_read_o     = w_fwd && !w_we;
  assign mem_funct3_o   = w_f3;
  assign mem_addr_o     = w_addr;
  assign mem_wdata_o    = w_wdata;
  // The burst-opening beat counts as busy so the flag spans every beat.
  assign busy_o         = w_in_burst || w_start;
  assign misalign_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Directed, table-driven bench for dmem_arbiter with a byte memory.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk, rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [2:0]  p0_f3, p1_f3;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [3:0]  p1_len;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_write, mem_read, busy, misalign_err;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0]  mem_arr [0:1023];
  int          n_tests = 0;
  int          n_fail  = 0;

  dmem_arbiter #(.LEN_W(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_funct3_i(p0_f3), .p0_addr_i(p0_addr),
    .p0_wdata_i(p0_wdata), .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_funct3_i(p1_f3), .p1_addr_i(p1_addr),
    .p1_wdata_i(p1_wdata), .p1_len_i(p1_len), .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rvalid),
    .p1_rdata_o(p1_rdata),
    .mem_write_o(mem_write), .mem_read_o(mem_read), .mem_funct3_o(mem_funct3),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .busy_o(busy), .misalign_err_o(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian byte memory, 1 KiB aliased over the address space.
  always_comb begin
    logic [9:0] a;
    a = mem_addr[9:0];
    mem_rdata = 32'h0;
    case (mem_funct3)
      3'b000: mem_rdata = {{24{mem_arr[a][7]}}, mem_arr[a]};
      3'b100: mem_rdata = {24'h0, mem_arr[a]};
      3'b001: mem_rdata = {{16{mem_arr[a+10'd1][7]}}, mem_arr[a+10'd1], mem_arr[a]};
      3'b101: mem_rdata = {16'h0, mem_arr[a+10'd1], mem_arr[a]};
      3'b010: mem_rdata = {mem_arr[a+10'd3], mem_arr[a+10'd2], mem_arr[a+10'd1], mem_arr[a]};
      default: mem_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write) begin
      mem_arr[mem_addr[9:0]] <= mem_wdata[7:0];
      if (mem_funct3[1:0] != 2'b00) mem_arr[mem_addr[9:0]+10'd1] <= mem_wdata[15:8];
      if (mem_funct3[1] == 1'b1) begin
        mem_arr[mem_addr[9:0]+10'd2] <= mem_wdata[23:16];
        mem_arr[mem_addr[9:0]+10'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic clr_inputs();
    p0_req = 0; p0_we = 0; p0_f3 = 3'b000; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_f3 = 3'b000; p1_addr = 0; p1_wdata = 0; p1_len = 0;
  endtask

  typedef struct packed {
    logic        p0_req; logic p0_we; logic [2:0] p0_f3; logic [31:0] p0_addr; logic [31:0] p0_wdata;
    logic        p1_req; logic p1_we; logic [2:0] p1_f3; logic [31:0] p1_addr; logic [31:0] p1_wdata;
    logic [3:0]  p1_len;
    logic        e_gnt0; logic e_gnt1; logic e_rd; logic e_wr; logic [31:0] e_addr; logic e_busy;
    logic        e_rv0; logic e_rv1; logic [31:0] e_rd0; logic [31:0] e_rd1; logic chk0; logic chk1;
  } vec_t;

  vec_t vecs [11];

  initial begin
    for (int i = 0; i < 1024; i++) mem_arr[i] = i[7:0];
    //             p0: req we f3 addr wdata          p1: req we f3 addr wdata len      gnt0 gnt1 rd wr addr busy rv0 rv1 rd0 rd1 c0 c1
    vecs[0]  = '{1'b0,1'b0,3'b000,32'h0,32'h0,          1'b0,1'b0,3'b000,32'h0,32'h0,4'd0,   1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,  1'b0,1'b0,32'h0,32'h0,1'b1,1'b1};
    vecs[1]  = '{1'b1,1'b0,3'b010,32'h100,32'h0,        1'b1,1'b0,3'b010,32'h204,32'h0,4'd0, 1'b1,1'b0,1'b1,1'b0,32'h100,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b0,3'b010,32'h100,32'h0,        1'b1,1'b0,3'b010,32'h204,32'h0,4'd0, 1'b0,1'b1,1'b1,1'b0,32'h204,1'b0,1'b1,1'b0,32'h03020100,32'h0,1'b1,1'b0};
    vecs[3]  = '{1'b1,1'b0,3'b010,32'h100,32'h0,        1'b1,1'b0,3'b010,32'h204,32'h0,4'd0, 1'b1,1'b0,1'b1,1'b0,32'h100,1'b0,1'b0,1'b1,32'h0,32'h07060504,1'b0,1'b1};
    vecs[4]  = '{1'b1,1'b0,3'b010,32'h100,32'h0,        1'b1,1'b0,3'b010,32'h204,32'h0,4'd0, 1'b0,1'b1,1'b1,1'b0,32'h204,1'b0,1'b1,1'b0,32'h03020100,32'h0,1'b1,1'b0};
    vecs[5]  = '{1'b1,1'b1,3'b010,32'h10,32'hDEADBEEF,  1'b0,1'b0,3'b000,32'h0,32'h0,4'd0,   1'b1,1'b0,1'b0,1'b1,32'h10,1'b0, 1'b0,1'b1,32'h0,32'h07060504,1'b0,1'b1};
    vecs[6]  = '{1'b1,1'b0,3'b010,32'h10,32'h0,         1'b0,1'b0,3'b000,32'h0,32'h0,4'd0,   1'b1,1'b0,1'b1,1'b0,32'h10,1'b0, 1'b1,1'b0,32'h0,32'h0,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,3'b000,32'h0,32'h0,          1'b0,1'b0,3'b000,32'h0,32'h0,4'd0,   1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,  1'b1,1'b0,32'hDEADBEEF,32'h0,1'b1,1'b0};
    vecs[8]  = '{1'b0,1'b0,3'b000,32'h0,32'h0,          1'b1,1'b0,3'b011,32'h40,32'h0,4'd0,  1'b0,1'b1,1'b0,1'b0,32'h40,1'b0, 1'b0,1'b0,32'h0,32'h0,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b0,3'b000,32'h0,32'h0,          1'b1,1'b0,3'b000,32'h85,32'h0,4'd0,  1'b0,1'b1,1'b1,1'b0,32'h85,1'b0, 1'b0,1'b1,32'h0,32'h0,1'b0,1'b1};
    vecs[10] = '{1'b0,1'b0,3'b000,32'h0,32'h0,          1'b0,1'b0,3'b000,32'h0,32'h0,4'd0,   1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,  1'b0,1'b1,32'h0,32'hFFFFFF85,1'b0,1'b1};

    rst = 1'b1;
    clr_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (i != 0) @(negedge clk);
      p0_req = vecs[i].p0_req; p0_we = vecs[i].p0_we; p0_f3 = vecs[i].p0_f3;
      p0_addr = vecs[i].p0_addr; p0_wdata = vecs[i].p0_wdata;
      p1_req = vecs[i].p1_req; p1_we = vecs[i].p1_we; p1_f3 = vecs[i].p1_f3;
      p1_addr = vecs[i].p1_addr; p1_wdata = vecs[i].p1_wdata; p1_len = vecs[i].p1_len;
      #2;
      chk($sformatf("v%0d p0_gnt", i), {31'h0, p0_gnt}, {31'h0, vecs[i].e_gnt0});
      chk($sformatf("v%0d p1_gnt", i), {31'h0, p1_gnt}, {31'h0, vecs[i].e_gnt1});
      chk($sformatf("v%0d mem_read", i), {31'h0, mem_read}, {31'h0, vecs[i].e_rd});
      chk($sformatf("v%0d mem_write", i), {31'h0, mem_write}, {31'h0, vecs[i].e_wr});
      chk($sformatf("v%0d busy", i), {31'h0, busy}, {31'h0, vecs[i].e_busy});
      chk($sformatf("v%0d p0_rvalid", i), {31'h0, p0_rvalid}, {31'h0, vecs[i].e_rv0});
      chk($sformatf("v%0d p1_rvalid", i), {31'h0, p1_rvalid}, {31'h0, vecs[i].e_rv1});
      chk($sformatf("v%0d misalign_err", i), {31'h0, misalign_err}, 32'h0);
      if (vecs[i].e_gnt0 || vecs[i].e_gnt1) chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      if (vecs[i].chk0) chk($sformatf("v%0d p0_rdata", i), p0_rdata, vecs[i].e_rd0);
      if (vecs[i].chk1) chk($sformatf("v%0d p1_rdata", i), p1_rdata, vecs[i].e_rd1);
    end

    // Byte-write burst crossing 0x200, with a stall; port 0 waits it out.
    @(negedge clk); clr_inputs();
    p1_req = 1; p1_we = 1; p1_f3 = 3'b000; p1_addr = 32'h1FE; p1_wdata = 32'h11; p1_len = 4'd3;
    #2;
    chk("b3 beat0 gnt", {31'h0, p1_gnt}, 32'h1);
    chk("b3 beat0 busy", {31'h0, busy}, 32'h1);
    chk("b3 beat0 write", {31'h0, mem_write}, 32'h1);
    chk("b3 beat0 addr", mem_addr, 32'h1FE);
    @(negedge clk);
    p1_wdata = 32'h22; p1_addr = 32'h0; p1_len = 4'd0;
    p0_req = 1; p0_we = 0; p0_f3 = 3'b010; p0_addr = 32'h200;
    #2;
    chk("b3 beat1 p0_gnt", {31'h0, p0_gnt}, 32'h0);
    chk("b3 beat1 p1_gnt", {31'h0, p1_gnt}, 32'h1);
    chk("b3 beat1 addr", mem_addr, 32'h1FF);
    chk("b3 beat1 wdata", mem_wdata, 32'h22);
    chk("b3 beat1 busy", {31'h0, busy}, 32'h1);
    @(negedge clk); p1_wdata = 32'h33; #2;
    chk("b3 beat2 addr", mem_addr, 32'h200);
    @(negedge clk); p1_req = 0; #2;
    chk("b3 stall p1_gnt", {31'h0, p1_gnt}, 32'h0);
    chk("b3 stall p0_gnt", {31'h0, p0_gnt}, 32'h0);
    chk("b3 stall write", {31'h0, mem_write}, 32'h0);
    chk("b3 stall busy", {31'h0, busy}, 32'h1);
    @(negedge clk); p1_req = 1; p1_wdata = 32'h44; #2;
    chk("b3 beat3 addr", mem_addr, 32'h201);
    chk("b3 beat3 busy", {31'h0, busy}, 32'h1);
    @(negedge clk); p1_req = 0; #2;
    chk("b3 after busy", {31'h0, busy}, 32'h0);
    chk("b3 after p0_gnt", {31'h0, p0_gnt}, 32'h1);
    @(negedge clk); p0_f3 = 3'b101; p0_addr = 32'h1FE; #2;
    chk("b3 rd word", p0_rdata, 32'h03024433);
    @(negedge clk); p0_req = 0; #2;
    chk("b3 rd half", p0_rdata, 32'h00002211);

    // Halfword read burst wrapping the top of the address space.
    @(negedge clk); clr_inputs();
    p1_req = 1; p1_f3 = 3'b001; p1_addr = 32'hFFFFFFFE; p1_len = 4'd1;
    #2;
    chk("b4 beat0 addr", mem_addr, 32'hFFFFFFFE);
    chk("b4 beat0 busy", {31'h0, busy}, 32'h1);
    @(negedge clk); #2;
    chk("b4 beat1 addr", mem_addr, 32'h00000000);
    chk("b4 beat0 rdata", p1_rdata, 32'hFFFFFFFE);
    @(negedge clk); p1_req = 0; #2;
    chk("b4 beat1 rdata", p1_rdata, 32'h00000100);
    chk("b4 end busy", {31'h0, busy}, 32'h0);

    // Reset lands on the third beat of an 8-beat byte-write burst.
    @(negedge clk); clr_inputs();
    p1_req = 1; p1_we = 1; p1_f3 = 3'b000; p1_addr = 32'h300; p1_wdata = 32'hA0; p1_len = 4'd7;
    @(negedge clk); p1_wdata = 32'hA1;
    @(negedge clk); p1_wdata = 32'hA2; rst = 1'b1; #2;
    chk("b5 rst busy", {31'h0, busy}, 32'h0);
    chk("b5 rst write", {31'h0, mem_write}, 32'h0);
    chk("b5 rst rvalid", {31'h0, p1_rvalid}, 32'h0);
    @(negedge clk); rst = 1'b0; p1_req = 0; #2;
    chk("b5 post busy", {31'h0, busy}, 32'h0);
    @(negedge clk); #2;
    chk("b5 mem 0x301", {24'h0, mem_arr[10'h301]}, 32'hA1);
    chk("b5 mem 0x302", {24'h0, mem_arr[10'h302]}, 32'h02);
    chk("b5 mem 0x303", {24'h0, mem_arr[10'h303]}, 32'h03);

    // Misaligned word load.
    @(negedge clk); clr_inputs();
    p0_req = 1; p0_f3 = 3'b010; p0_addr = 32'h22; #2;
    chk("b6 gnt", {31'h0, p0_gnt}, 32'h1);
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    chk("b6 mem_read", {31'h0, mem_read}, 32'h0);
    @(negedge clk); p0_req = 0; #2;
    chk("b6 rvalid", {31'h0, p0_rvalid}, 32'h1);
    chk("b6 rdata", p0_rdata, 32'h0);
    chk("b6 err", {31'h0, misalign_err}, 32'h1);
`else
    chk("b6 mem_read", {31'h0, mem_read}, 32'h1);
    @(negedge clk); p0_req = 0; #2;
    chk("b6 rvalid", {31'h0, p0_rvalid}, 32'h1);
    chk("b6 rdata", p0_rdata, 32'h25242322);
    chk("b6 err", {31'h0, misalign_err}, 32'h0);
`endif
    @(negedge clk); #2;
    chk("b6 err clear", {31'h0, misalign_err}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
